seg7_display: RTL
=================

Name: seg7_display

Overview:
- Output stage downstream of the computer top. Consumes the 16-bit CPU result bus that currently drives the LEDs and shows it on a 4-digit multiplexed, common-anode seven-segment display.
- Two display modes, selected at run time:
  - Hex mode shows the value directly.
  - Decimal mode converts it to BCD with a sequential double-dabble engine, one shift per clock.
- A refresh counter scans the digits.

Parameters:
- REFRESH_DIV, 100000: clock cycles each digit stays enabled (1 kHz per digit at 100 MHz); legal range ≥ 4.
- WIDTH, 16: input value width; fixed at 16 for this revision.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- value  input  16  unsigned result to display (the CPU outM/led_output bus).
- dec_mode  input  1  1 = decimal, 0 = hexadecimal.
- seg  output  7  segment drive, active-low, ordered {g,f,e,d,c,b,a}.
- dp  output  1  decimal point, active-low.
- an  output  4  digit anodes, active-low; an[0] = rightmost digit.
- busy  output  1  high while a conversion is in flight (LOAD/SHIFT/DONE).

Behaviour:
- Reset (reset=0, asynchronous):
  - Outputs: seg=7'h7F, dp=1, an=4'hF, busy=0.
  - State: disp_reg=0, ovf_reg=0, scan counter=0, digit index=0, FSM=IDLE.
  - The pending flag is set, so a conversion starts on the first clock after release.
- Change detect: pending is set whenever value ≠ last_value or dec_mode ≠ last_mode, sampled every cycle, including during a conversion.
- FSM states:
  - IDLE: if pending → LOAD.
  - LOAD: capture value into shift_src and dec_mode into mode_q, update last_value/last_mode, clear pending, clear bcd accumulator (20 bits). Next state: SHIFT if mode_q=1, else DONE.
  - SHIFT: 16 iterations over counter 0..15. Each cycle, every BCD nibble ≥5 gets +3, then {bcd,shift_src} shifts left 1. After iteration 15 → DONE.
  - DONE: update the display registers, then → IDLE.
    - Decimal: disp_reg = bcd[15:0]; ovf_reg = (bcd[19:16] ≠ 0).
    - Hex: disp_reg = shift_src; ovf_reg = 0.
- Latency, from the value change edge to disp_reg updated:
  - Decimal: 19 cycles (detect + LOAD + 16 SHIFT + DONE).
  - Hex: 3 cycles.
- Value changes mid-conversion:
  - The in-flight conversion completes with the old sample.
  - Pending remains set, so a new conversion starts from IDLE the cycle after DONE.
  - Intermediate values may be skipped; the final displayed value always equals the last stable input.
- Display is glitch-free: disp_reg changes only in DONE. Partial BCD never reaches seg.
- Scan:
  - Counter counts 0..REFRESH_DIV-1.
  - On wrap, digit index increments mod 4 (3→0).
  - an = ~(1<<index).
  - Scanning is independent of the FSM.
- Digit decode:
  - Nibble to seg: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E (hex).
- Leading-zero blanking, decimal mode only:
  - A digit whose nibble and all higher nibbles are zero drives seg=7F.
  - Digit 0 is never blanked.
  - Hex mode shows all four digits.
- dp:
  - Low only on digit 3, and only when ovf_reg=1 (decimal value > 9999; the lower 4 digits are shown).
  - High otherwise.
- busy = (FSM ≠ IDLE).
- Reset mid-conversion: immediate return to reset values; the conversion is discarded and restarts after release.

Test Plan:
- Reset release with value=0, dec_mode=1 → busy high for 18 cycles. Digit 0 then shows seg=40; digits 1-3 show 7F; dp=1 everywhere.
- dec_mode=1, value=1234 → after 19 cycles, digits 3..0 = 79,24,30,19; dp=1.
- dec_mode=1, value=12345 → digits 3..0 = 24,30,19,12 (2345); dp=0 only while an=4'b0111.
- dec_mode=0, value=16'hBEEF → after 3 cycles, digits 3..0 = 03,06,06,0E; no blanking. Then value=16'h0001 → digits 3..1 show 40 (not blanked).
- value changes 100→200→300 on consecutive cycles during SHIFT → first conversion finishes with 100, next conversion loads 300. Final display = 300, with exactly 2 DONE events.
- REFRESH_DIV=4 → an cycles E,D,B,7 every 4 clocks, wrapping to E. Asserting reset mid-SHIFT → seg=7F, an=F, busy=0 immediately (asynchronously).

Source files
------------

// File: rtl/seg7_display.sv
// rtl/seg7_display.sv - 4-digit multiplexed common-anode seven-segment display driver
// Hex or decimal (sequential double-dabble) rendering of a 16-bit value.
module seg7_display #(
   parameter int REFRESH_DIV = 100000,
   parameter int WIDTH       = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] value,
   input  logic             dec_mode,
   output logic [6:0]       seg,
   output logic             dp,
   output logic [3:0]       an,
   output logic             busy
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] LOAD  = 2'd1;
   localparam logic [1:0] SHIFT = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;

   localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

   logic [1:0]       state;
   logic             pending;
   logic [WIDTH-1:0] lastValue;
   logic             lastMode;
   logic [WIDTH-1:0] shiftSrc;
   logic             modeQ;
   logic [19:0]      bcd;
   logic [19:0]      bcdAdj;
   logic [3:0]       bitCnt;
   logic [15:0]      dispReg;
   logic             ovfReg;
   logic             dispMode;
   logic [CNT_W-1:0] scanCnt;
   logic [1:0]       digitIdx;
   logic             changeNow;
   logic [15:0]      shifted;
   logic             blank;
   logic [6:0]       segNext;

   assign changeNow = (value != lastValue) || (dec_mode != lastMode);
   assign busy      = (state != IDLE);

   always_comb begin
      bcdAdj = bcd;
      for (int i = 0; i < 5; i++) begin
         if (bcd[4*i +: 4] >= 4'd5) bcdAdj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
   end

   // A change seen while converting stays latched in pending, so the
   // display always settles on the last stable input.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         pending   <= 1'b1;
         lastValue <= '0;
         lastMode  <= 1'b0;
         shiftSrc  <= '0;
         modeQ     <= 1'b0;
         bcd       <= '0;
         bitCnt    <= '0;
         dispReg   <= '0;
         ovfReg    <= 1'b0;
         dispMode  <= 1'b0;
      end else begin
         if (state != LOAD && changeNow) pending <= 1'b1;
         case (state)
            IDLE: if (pending || changeNow) state <= LOAD;
            LOAD: begin
               shiftSrc  <= value;
               modeQ     <= dec_mode;
               lastValue <= value;
               lastMode  <= dec_mode;
               pending   <= 1'b0;
               bcd       <= '0;
               bitCnt    <= '0;
               state     <= dec_mode ? SHIFT : DONE;
            end
            SHIFT: begin
               {bcd, shiftSrc} <= {bcdAdj, shiftSrc} << 1;
               bitCnt          <= bitCnt + 4'd1;
               if (bitCnt == 4'd15) state <= DONE;
            end
            default: begin
               if (modeQ) begin
                  dispReg <= bcd[15:0];
                  ovfReg  <= (bcd[19:16] != 4'd0);
               end else begin
                  dispReg <= shiftSrc;
                  ovfReg  <= 1'b0;
               end
               dispMode <= modeQ;
               state    <= IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         scanCnt  <= '0;
         digitIdx <= 2'd0;
      end else if (scanCnt == CNT_LAST) begin
         scanCnt  <= '0;
         digitIdx <= digitIdx + 2'd1;
      end else begin
         scanCnt <= scanCnt + 1'b1;
      end
   end

   function automatic logic [6:0] decode(input logic [3:0] nib);
      case (nib)
         4'h0: decode = 7'h40;
         4'h1: decode = 7'h79;
         4'h2: decode = 7'h24;
         4'h3: decode = 7'h30;
         4'h4: decode = 7'h19;
         4'h5: decode = 7'h12;
         4'h6: decode = 7'h02;
         4'h7: decode = 7'h78;
         4'h8: decode = 7'h00;
         4'h9: decode = 7'h10;
         4'hA: decode = 7'h08;
         4'hB: decode = 7'h03;
         4'hC: decode = 7'h46;
         4'hD: decode = 7'h21;
         4'hE: decode = 7'h06;
         default: decode = 7'h0E;
      endcase
   endfunction

   // Shifting out the lower digits leaves only this nibble and those above it,
   // which is exactly the leading-zero test.
   always_comb begin
      shifted = dispReg >> {digitIdx, 2'b00};
      blank   = dispMode && (digitIdx != 2'd0) && (shifted == 16'd0);
      segNext = blank ? 7'h7F : decode(shifted[3:0]);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         seg <= 7'h7F;
         dp  <= 1'b1;
         an  <= 4'hF;
      end else begin
         seg <= segNext;
         dp  <= !((digitIdx == 2'd3) && ovfReg);
         an  <= ~(4'b0001 << digitIdx);
      end
   end

endmodule
